// File: rtl/ifetch_pkg.sv
// Shared types and opcode constants for the instruction-fetch stage.
package ifetch_pkg;

  localparam int INSTR_W = 32;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
    logic [31:0]        pc4;
    logic               jpred;
  } fetch_entry_t;

  function automatic logic is_jump(input logic [INSTR_W-1:0] instr);
    return (instr[OPC_MSB:OPC_LSB] == OP_J) || (instr[OPC_MSB:OPC_LSB] == OP_JAL);
  endfunction

endpackage

// File: rtl/ifetch_prefetch_if.sv
// Fetch-stage bus bundle: ROM request/response, redirect input and decode-side queue head.
interface ifetch_prefetch_if #(
  parameter int IMEM_AW = 14
);
  import ifetch_pkg::*;

  logic                 imem_en;
  logic [IMEM_AW-1:0]   imem_addr;
  logic [INSTR_W-1:0]   imem_rdata;
  logic                 redirect_valid;
  logic [31:0]          redirect_pc;
  logic                 out_valid;
  logic                 out_ready;
  logic [INSTR_W-1:0]   out_instr;
  logic [31:0]          out_pc;
  logic [31:0]          out_pc4;
  logic                 out_jpred;
  logic                 misalign;

  modport master (
    output imem_en, imem_addr,
    input  imem_rdata,
    input  redirect_valid, redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instr, out_pc, out_pc4, out_jpred, misalign
  );

  modport slave (
    input  imem_en, imem_addr,
    output imem_rdata,
    output redirect_valid, redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instr, out_pc, out_pc4, out_jpred, misalign
  );

endinterface

// File: rtl/ifetch_fifo.sv
// Synchronous FIFO of fetch entries with single-cycle flush; head is read straight from storage.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             din,
  input  logic                     pop,
  output fetch_entry_t             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full queue may still accept a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ifetch_prefetch.sv
// Decoupled instruction fetch: PC, credit-based ROM requests, return queue, redirect flush.
// Optional j/jal predecode is enabled by defining IFETCH_JPREDECODE_EN.
module ifetch_prefetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4,
  parameter int          IMEM_AW  = 14
) (
  input  logic               clk,
  input  logic               reset,
  ifetch_prefetch_if.master  bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   fetch_pc;
  logic          infl_vld_p1;
  logic [31:0]   infl_pc_p1;
  logic          misalign_p1;

  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;

  logic          pop;
  logic          push;
  logic          issue;
  logic          ret_vld;
  logic          jdet;
  logic [31:0]   jtarget;
  logic [CW:0]   credit_need;

  assign pop = !fifo_empty && bus.out_ready;

  // Slots already owed: queued entries plus the response still on its way, minus the one leaving.
  assign credit_need = {1'b0, fifo_count} + {{CW{1'b0}}, infl_vld_p1} - {{CW{1'b0}}, pop};
  assign issue       = !reset && !bus.redirect_valid && (credit_need < (CW+1)'(DEPTH));

  assign bus.imem_en   = issue;
  assign bus.imem_addr = fetch_pc[IMEM_AW+1:2];

  assign ret_vld = infl_vld_p1 && !bus.redirect_valid;
  assign push    = ret_vld && (!fifo_full || pop);

`ifdef IFETCH_JPREDECODE_EN
  assign jdet    = ret_vld && is_jump(bus.imem_rdata);
  assign jtarget = {push_entry.pc4[31:28], bus.imem_rdata[25:0], 2'b00};
`else
  assign jdet    = 1'b0;
  assign jtarget = '0;
`endif

  always_comb begin
    push_entry       = '0;
    push_entry.instr = bus.imem_rdata;
    push_entry.pc    = infl_pc_p1;
    push_entry.pc4   = infl_pc_p1 + 32'd4;
    push_entry.jpred = jdet;
  end

  // Stage p0 -> p1: request issue, PC advance, redirect/predecode steering
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      infl_vld_p1 <= 1'b0;
      misalign_p1 <= 1'b0;
    end else begin
      misalign_p1 <= bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
      infl_vld_p1 <= issue && !jdet;
      if (bus.redirect_valid)
        fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
      else if (jdet)
        fetch_pc <= jtarget;
      else if (issue)
        fetch_pc <= fetch_pc + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) infl_pc_p1 <= fetch_pc;
  end

  // Stage p1 -> p2: returned word enters the queue
  ifetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (bus.redirect_valid),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.out_valid = !fifo_empty;
  assign bus.out_instr = head.instr;
  assign bus.out_pc    = head.pc;
  assign bus.out_pc4   = head.pc4;
  assign bus.out_jpred = head.jpred && !fifo_empty;
  assign bus.misalign  = misalign_p1;

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Bench for ifetch_prefetch: program-order stream model plus directed scenarios.
module tb_ifetch_prefetch;
  import ifetch_pkg::*;

  localparam int          IMEM_AW  = 14;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IFETCH_JPREDECODE_EN
  localparam bit JPD = 1'b1;
`else
  localparam bit JPD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ifetch_prefetch_if #(.IMEM_AW(IMEM_AW)) bus ();

  ifetch_prefetch #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH),
    .IMEM_AW  (IMEM_AW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] rom [0:(1<<IMEM_AW)-1];
  always @(posedge clk) if (bus.imem_en) bus.imem_rdata <= rom[bus.imem_addr];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Stream model: decode must see instructions in program order from the last reset/redirect.
  logic [31:0] exp_pc;
  logic [31:0] exp_instr;
  bit          exp_j;
  bit          model_on = 1'b0;
  bit          prev_reset = 1'b0;
  bit          prev_redir = 1'b0;
  bit          mis_exp = 1'b0;
  logic [31:0] pop_log [$];

  always @(negedge clk) begin
    if (model_on) begin
      if (prev_reset || prev_redir) chk("valid_after_flush", {31'd0, bus.out_valid}, 32'd0);
      if (prev_reset) chk("jpred_after_reset", {31'd0, bus.out_jpred}, 32'd0);
      chk("misalign", {31'd0, bus.misalign}, {31'd0, mis_exp});
      if (reset || bus.redirect_valid) chk("imem_en_blocked", {31'd0, bus.imem_en}, 32'd0);
      if (reset) begin
        exp_pc = RESET_PC;
      end else begin
        if (bus.out_valid && bus.out_ready) begin
          exp_instr = rom[exp_pc[IMEM_AW+1:2]];
          exp_j = JPD && (exp_instr[31:26] == 6'h02 || exp_instr[31:26] == 6'h03);
          chk("out_pc", bus.out_pc, exp_pc);
          chk("out_instr", bus.out_instr, exp_instr);
          chk("out_pc4", bus.out_pc4, exp_pc + 32'd4);
          chk("out_jpred", {31'd0, bus.out_jpred}, {31'd0, exp_j});
          pop_log.push_back(bus.out_pc);
          if (exp_j) exp_pc = {exp_pc[31:28] + ((exp_pc[27:0] + 28'd4 == 28'd0) ? 4'd1 : 4'd0),
                               exp_instr[25:0], 2'b00};
          else       exp_pc = exp_pc + 32'd4;
        end
        if (bus.redirect_valid) exp_pc = {bus.redirect_pc[31:2], 2'b00};
      end
    end
    if (reset) model_on = 1'b1;
    mis_exp    = !reset && bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
    prev_reset = reset;
    prev_redir = bus.redirect_valid;
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_pops(input int n);
    int k = 0;
    while (pop_log.size() < n && k < 200) begin
      @(negedge clk);
      k++;
    end
    #1;
    if (pop_log.size() < n) chk("pop_timeout", pop_log.size(), n);
  endtask

  task automatic redirect(input logic [31:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    step();
    bus.redirect_valid = 1'b0;
  endtask

  task automatic chk_log(input string name, input int idx, input logic [31:0] req);
    if (pop_log.size() > idx) chk(name, pop_log[idx], req);
    else                      chk({name, "_missing"}, pop_log.size(), idx + 1);
  endtask

  initial begin
    int lat;
    int n_en;
    int n_val;
    for (int i = 0; i < (1 << IMEM_AW); i++) rom[i] = i;
    reset              = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;
    bus.out_ready      = 1'b1;
    step(3);

    // 1: reset release, streaming latency and order
    reset = 1'b0;
    pop_log.delete();
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      if (bus.out_valid) break;
      lat++;
    end
    chk("t1_first_valid_cycle", lat, 2);
    chk("t1_first_pc", bus.out_pc, 32'h0);
    chk("t1_first_instr", bus.out_instr, 32'h0);
    n_val = 0;
    repeat (8) begin
      @(negedge clk);
      n_val += bus.out_valid ? 1 : 0;
    end
    chk("t1_sustained", n_val, 8);
    wait_pops(6);
    for (int i = 0; i < 6; i++) chk_log("t1_pc_seq", i, 32'(4 * i));

    // 2: stall fill with exactly DEPTH requests, then gapless drain
    step();
    bus.out_ready = 1'b0;
    redirect(32'h200);
    n_en = 0;
    repeat (10) begin
      @(negedge clk);
      n_en += bus.imem_en ? 1 : 0;
    end
    chk("t2_fill_issues", n_en, DEPTH);
    chk("t2_en_low_full", {31'd0, bus.imem_en}, 32'd0);
    chk("t2_head_valid", {31'd0, bus.out_valid}, 32'd1);
    step();
    pop_log.delete();
    bus.out_ready = 1'b1;
    n_val = 0;
    repeat (10) begin
      @(negedge clk);
      n_val += bus.out_valid ? 1 : 0;
    end
    chk("t2_no_gap", n_val, 10);
    wait_pops(10);
    for (int i = 0; i < 10; i++) chk_log("t2_pc_seq", i, 32'h200 + 32'(4 * i));

    // 3: flush with queued entries and a request in flight
    step();
    bus.out_ready = 1'b0;
    redirect(32'h10);
    step(4);
    redirect(32'h100);
    pop_log.delete();
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("t3_valid_low", {31'd0, bus.out_valid}, 32'd0);
    wait_pops(3);
    chk_log("t3_pc0", 0, 32'h100);
    chk_log("t3_pc1", 1, 32'h104);
    chk_log("t3_pc2", 2, 32'h108);

    // 4: misaligned redirect
    step();
    redirect(32'h102);
    pop_log.delete();
    @(negedge clk);
    chk("t4_misalign_pulse", {31'd0, bus.misalign}, 32'd1);
    @(negedge clk);
    chk("t4_misalign_clear", {31'd0, bus.misalign}, 32'd0);
    wait_pops(1);
    chk_log("t4_pc0", 0, 32'h100);

    // 5: PC wrap
    step();
    redirect(32'hFFFF_FFFC);
    pop_log.delete();
    wait_pops(3);
    chk_log("t5_pc0", 0, 32'hFFFF_FFFC);
    chk_log("t5_pc1", 1, 32'h0000_0000);
    chk_log("t5_pc2", 2, 32'h0000_0004);

    // back-to-back redirects: last one wins
    step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h300;
    step();
    bus.redirect_pc    = 32'h400;
    step();
    bus.redirect_valid = 1'b0;
    pop_log.delete();
    wait_pops(2);
    chk_log("b2b_pc0", 0, 32'h400);
    chk_log("b2b_pc1", 1, 32'h404);

    // 6: mid-stream reset, jal at 0x8 targeting 0x40
    step();
    reset  = 1'b1;
    rom[2] = {6'h03, 26'h000_0010};
    step(2);
    reset = 1'b0;
    pop_log.delete();
    wait_pops(6);
    chk_log("t6_pc0", 0, 32'h0);
    chk_log("t6_pc1", 1, 32'h4);
    chk_log("t6_pc2", 2, 32'h8);
    chk_log("t6_pc3", 3, JPD ? 32'h40 : 32'hC);
    chk_log("t6_pc4", 4, JPD ? 32'h44 : 32'h10);

    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
